// File: rtl/info_uart_pkg.sv
// info_uart_pkg: shared FSM state type, ASCII constants and the nibble-to-hex
// helper used by the info_hex_uart status-word printer.
package info_uart_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, NEXT} state_t;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_BANG = 8'h21;

  // 0-9 map onto '0'..'9'; 10-15 onto 'A'..'F' (8'h37 + 10 = 8'h41).
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/info_fifo.sv
// info_fifo: 2**DEPTH_BITS-deep word FIFO with simultaneous push/pop, a
// saturating-free occupancy count (never exceeds depth) and a combinational head read.
module info_fifo #(
  parameter int DEPTH_BITS = 4,
  parameter int WIDTH      = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                push_i,
  input  logic [WIDTH-1:0]    wdata_i,
  input  logic                pop_i,
  output logic [WIDTH-1:0]    rdata_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [DEPTH_BITS:0] count_o
);

  localparam int DEPTH = 2 ** DEPTH_BITS;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q;
  logic [DEPTH_BITS-1:0] rd_ptr_q;
  logic [DEPTH_BITS:0]   count_q;
  logic                  do_push;
  logic                  do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = count_q[DEPTH_BITS];
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/info_hex_uart.sv
// info_hex_uart: buffers strobed 16-bit status words and prints each on an 8N1
// TX-only UART as 4 hex chars + CR LF. INFO_UART_OVERFLOW_MARK_EN adds a '!' prefix after drops.
module info_hex_uart
  import info_uart_pkg::*;
#(
  parameter int CLKDIV     = 217,
  parameter int DEPTH_BITS = 4,
  parameter int DWIDTH     = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DWIDTH-1:0]   info,
  input  logic                info_e,
  output logic                tx,
  output logic                busy,
  output logic                overflow,
  output logic [DEPTH_BITS:0] fifo_count
);

  localparam int            TW         = $clog2(CLKDIV);
  localparam logic [TW-1:0] BIT_RELOAD = TW'(CLKDIV - 1);

  state_t            state_q;
  logic [TW-1:0]     timer_q;
  logic [2:0]        bit_cnt_q;
  logic [2:0]        char_idx_q;
  logic [7:0]        shreg_q;
  logic [DWIDTH-1:0] line_word_q;
  logic              tx_q;
  logic              busy_q;
  logic              overflow_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DWIDTH-1:0] fifo_rdata;
  logic              pop;
  logic              drop;
  logic [2:0]        char_sel;
  logic [2:0]        hex_sel;
  logic [2:0]        last_idx;
  logic [7:0]        char_byte;

  assign pop  = (state_q == IDLE) && !fifo_empty;
  assign drop = info_e && fifo_full && !pop;

  info_fifo #(
    .DEPTH_BITS (DEPTH_BITS),
    .WIDTH      (DWIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (info_e),
    .wdata_i (info),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef INFO_UART_OVERFLOW_MARK_EN
  logic mark_q;
  logic line_mark_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mark_q      <= 1'b0;
      line_mark_q <= 1'b0;
    end else if (pop) begin
      line_mark_q <= mark_q;
      mark_q      <= 1'b0;
    end else if (drop) begin
      mark_q <= 1'b1;
    end
  end

  assign last_idx = line_mark_q ? 3'd6 : 3'd5;
`else
  assign last_idx = 3'd5;
`endif

  // Character to load next: index 0 while in LOAD, otherwise the one after char_idx.
  always_comb begin
    char_sel = (state_q == LOAD) ? 3'd0 : char_idx_q + 3'd1;
    hex_sel  = char_sel;
`ifdef INFO_UART_OVERFLOW_MARK_EN
    if (line_mark_q) hex_sel = char_sel - 3'd1;
`endif
    case (hex_sel)
      3'd0:    char_byte = hex_ascii(line_word_q[15:12]);
      3'd1:    char_byte = hex_ascii(line_word_q[11:8]);
      3'd2:    char_byte = hex_ascii(line_word_q[7:4]);
      3'd3:    char_byte = hex_ascii(line_word_q[3:0]);
      3'd4:    char_byte = ASCII_CR;
      default: char_byte = ASCII_LF;
    endcase
`ifdef INFO_UART_OVERFLOW_MARK_EN
    if (line_mark_q && char_sel == 3'd0) char_byte = ASCII_BANG;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      char_idx_q  <= '0;
      shreg_q     <= '0;
      line_word_q <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      busy_q <= 1'b1;
      if (drop) overflow_q <= 1'b1;
      case (state_q)
        IDLE: begin
          busy_q <= info_e;
          if (pop) begin
            line_word_q <= fifo_rdata;
            busy_q      <= 1'b1;
            state_q     <= LOAD;
          end
        end
        LOAD: begin
          char_idx_q <= '0;
          shreg_q    <= char_byte;
          tx_q       <= 1'b0;
          timer_q    <= BIT_RELOAD;
          state_q    <= START;
        end
        START: begin
          if (timer_q == '0) begin
            timer_q   <= BIT_RELOAD;
            bit_cnt_q <= '0;
            tx_q      <= shreg_q[0];
            state_q   <= DATA;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        DATA: begin
          if (timer_q == '0) begin
            timer_q <= BIT_RELOAD;
            if (bit_cnt_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              shreg_q   <= {1'b0, shreg_q[7:1]};
              tx_q      <= shreg_q[1];
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        STOP: begin
          if (timer_q == '0) state_q <= NEXT;
          else               timer_q <= timer_q - 1'b1;
        end
        NEXT: begin
          if (char_idx_q == last_idx) begin
            busy_q  <= (fifo_count != '0) || info_e;
            state_q <= IDLE;
          end else begin
            char_idx_q <= char_idx_q + 3'd1;
            shreg_q    <= char_byte;
            tx_q       <= 1'b0;
            timer_q    <= BIT_RELOAD;
            state_q    <= START;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_info_hex_uart.sv
// Bench for info_hex_uart: a mid-bit-sampling UART receiver collects the printed
// characters; a queue model predicts text, drops, occupancy, overflow and busy.
module tb_info_hex_uart;

  localparam int C        = 4;
  localparam int DB       = 2;
  localparam int DEPTH    = 1 << DB;
  localparam int CHAR_CYC = 10 * C + 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] info = '0;
  logic        info_e = 1'b0;
  logic        tx;
  logic        busy;
  logic        overflow;
  logic [DB:0] fifo_count;

  info_hex_uart #(
    .CLKDIV     (C),
    .DEPTH_BITS (DB),
    .DWIDTH     (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .info       (info),
    .info_e     (info_e),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic [31:0] text;
  } vec_t;
  vec_t tbl [4];

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          free_at = 0;
  int          last_pop = 0;
  int          framing = 0;
  logic [15:0] mq [$];
  logic [7:0]  exp_q [$];
  logic [7:0]  rx_q [$];
  logic        m_ovf = 1'b0;
  logic        m_mark = 1'b0;
  logic        m_dropped = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] hexc(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  // Model of one printed line: queue its characters and occupy the printer.
  task automatic emit_line(input logic [15:0] w);
    int nchar;
    nchar = 6;
`ifdef INFO_UART_OVERFLOW_MARK_EN
    if (m_mark) begin
      exp_q.push_back(8'h21);
      m_mark = 1'b0;
      nchar = 7;
    end
`endif
    for (int k = 3; k >= 0; k--) exp_q.push_back(hexc((int'(w) >> (4 * k)) % 16));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    last_pop = cyc;
    free_at  = cyc + 2 + nchar * CHAR_CYC;
  endtask

  task automatic step(input logic push, input logic [15:0] w);
    logic full;
    logic pop;
    info_e = push;
    info   = w;
    @(posedge clk);
    cyc++;
    m_dropped = 1'b0;
    if (!reset_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_mark = 1'b0;
      free_at = 0;
    end else begin
      full = (mq.size() == DEPTH);
      pop  = (mq.size() != 0) && (cyc >= free_at);
      if (push && full && !pop) begin
        m_ovf = 1'b1;
        m_mark = 1'b1;
        m_dropped = 1'b1;
      end
      if (pop) emit_line(mq.pop_front());
      if (push && !m_dropped) mq.push_back(w);
    end
    #1;
    info_e = 1'b0;
    check("fifo_count", 32'(fifo_count), 32'(mq.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("busy", 32'(busy), 32'((cyc < free_at - 1) || (mq.size() != 0)));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((mq.size() != 0 || cyc < free_at + 2) && n < 6000) begin
      step(1'b0, '0);
      n++;
    end
    check({name, "_drain_bound"}, 32'(n < 6000), 32'd1);
    check({name, "_tx_idle"}, 32'(tx), 32'd1);
  endtask

  task automatic compare_lines(input string name);
    check({name, "_nchars"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s_char%0d", name, i), 32'(rx_q[i]), 32'(exp_q[i]));
    check({name, "_framing"}, 32'(framing), 32'd0);
    rx_q.delete();
    exp_q.delete();
    framing = 0;
  endtask

  task automatic check_text(input string name, input int base, input int v);
    logic [31:0] t;
    t = tbl[v].text;
    if (rx_q.size() >= base + 6) begin
      for (int k = 0; k < 4; k++)
        check($sformatf("%s_hex%0d", name, k), 32'(rx_q[base + k]), 32'(t[31 - 8 * k -: 8]));
      check({name, "_cr"}, 32'(rx_q[base + 4]), 32'h0D);
      check({name, "_lf"}, 32'(rx_q[base + 5]), 32'h0A);
    end else begin
      check({name, "_len"}, 32'(rx_q.size()), 32'(base + 6));
    end
  endtask

  // UART receiver: start detected on the first low sample, each bit sampled mid-cell.
  initial begin : rx_proc
    logic       prev;
    logic       aborted;
    logic [9:0] bits;
    int         n;
    prev = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && prev && tx === 1'b0) begin
        aborted = 1'b0;
        bits = '1;
        for (int b = 0; b < 10 && !aborted; b++) begin
          n = (b == 0) ? C / 2 : C;
          for (int j = 0; j < n && !aborted; j++) begin
            @(posedge clk);
            #1;
            if (!reset_n) aborted = 1'b1;
          end
          bits[b] = tx;
        end
        if (!aborted) begin
          if (bits[0] !== 1'b0 || bits[9] !== 1'b1) framing++;
          else rx_q.push_back(bits[8:1]);
        end
      end
      prev = (tx !== 1'b0);
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int          n0;
    int          target;
    int          gap;
    int          bangs;
    logic [15:0] w;

    tbl[0] = '{16'h40EE, "40EE"};
    tbl[1] = '{16'h0000, "0000"};
    tbl[2] = '{16'hFFFF, "FFFF"};
    tbl[3] = '{16'h9A5F, "9A5F"};

    // Reset state
    repeat (3) step(1'b0, '0);
    check("reset_tx", 32'(tx), 32'd1);
    reset_n = 1'b1;
    step(1'b0, '0);

    // Single word, then busy must be gone 252 clocks after the strobe
    step(1'b1, tbl[0].word);
    $display("t1 push word=%04h", tbl[0].word);
    n0 = cyc;
    while (cyc < n0 + 252) step(1'b0, '0);
    check("t1_busy_252", 32'(busy), 32'd0);
    drain("t1");
    check_text("t1", 0, 0);
    compare_lines("t1");

    // Hex edge words, back to back, printed in order
    for (int v = 1; v < 4; v++) begin
      step(1'b1, tbl[v].word);
      $display("t2 push word=%04h", tbl[v].word);
    end
    drain("t2");
    for (int v = 1; v < 4; v++) check_text($sformatf("t2_w%0d", v), 6 * (v - 1), v);
    compare_lines("t2");

    // Full FIFO with a push on the exact pop cycle
    step(1'b1, 16'h1234);
    step(1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 16'hA000 + 16'(i));
    while (cyc + 1 < free_at) step(1'b0, '0);
    step(1'b1, 16'hBEEF);
    $display("t4 push on pop cycle word=BEEF count=%0d overflow=%0d", fifo_count, overflow);
    check("t4_count", 32'(fifo_count), 32'd4);
    check("t4_overflow", 32'(overflow), 32'd0);
    drain("t4");
    compare_lines("t4");

    // Six strobes from empty: sixth is dropped, overflow sticks
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 16'h3000 + 16'(i * 16'h111));
      $display("t3 push word=%04h dropped=%0d", 16'h3000 + 16'(i * 16'h111), m_dropped);
    end
    check("t3_overflow_set", 32'(overflow), 32'd1);
    drain("t3");
    check("t3_overflow_sticky", 32'(overflow), 32'd1);
    bangs = 0;
    foreach (rx_q[i]) if (rx_q[i] == 8'h21) bangs++;
`ifdef INFO_UART_OVERFLOW_MARK_EN
    check("t6_nchars", 32'(rx_q.size()), 32'd31);
    if (rx_q.size() > 6) check("t6_bang_pos", 32'(rx_q[6]), 32'h21);
    check("t6_bang_count", 32'(bangs), 32'd1);
`else
    check("t3_nchars", 32'(rx_q.size()), 32'd30);
    check("t3_bang_count", 32'(bangs), 32'd0);
`endif
    compare_lines("t3");

    // Asynchronous reset in the middle of char 2's data bits
    step(1'b1, 16'hC0DE);
    step(1'b1, 16'h5A5A);
    target = last_pop + 1 + 2 * CHAR_CYC + 3 * C + 1;
    while (cyc < target) step(1'b0, '0);
    #2;
    reset_n = 1'b0;
    #1;
    $display("t5 reset asserted mid-character tx=%0d count=%0d", tx, fifo_count);
    check("t5_tx", 32'(tx), 32'd1);
    check("t5_count", 32'(fifo_count), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_overflow", 32'(overflow), 32'd0);
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    step(1'b0, '0);
    step(1'b0, '0);
    reset_n = 1'b1;
    step(1'b1, 16'h7B2C);
    $display("t5 push word=7B2C");
    drain("t5");
    compare_lines("t5");

    // Random words with bursts and pauses against the model
    for (int i = 0; i < 40; i++) begin
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 300)) : int'($urandom_range(0, 2));
      w = 16'($urandom);
      repeat (gap) step(1'b0, '0);
      step(1'b1, w);
      $display("rand push %0d word=%04h dropped=%0d count=%0d", i, w, m_dropped, fifo_count);
    end
    drain("rand");
    compare_lines("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
